alarm_slot_loader: RTL and testbench
====================================

# alarm_slot_loader

Parametrised successor to the single-time loader. It holds `NUM_SLOTS` independent hour/minute registers (the clock time plus alarms) and edits the slot selected by `sel_slot` from the `hour`, `minute` and `down` buttons. A held button auto-repeats. Outputs are the selected slot's binary counts, packed BCD digits with 12/24-hour decode, and the PM flag. The BCD outputs feed the existing digit/segment drivers directly.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of stored times; slot 0 is conventionally the running clock.
- `SLOT_W`, 2: width of `sel_slot`; must satisfy 2^SLOT_W >= NUM_SLOTS.
- `REPEAT_DELAY`, 50_000_000: cycles a button must be held after the first step before auto-repeat starts.
- `REPEAT_PERIOD`, 10_000_000: cycles between auto-repeat steps.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: edit enable; when low, no slot changes.
- `sel_slot`, in, SLOT_W: slot to edit and display; values >= NUM_SLOTS select slot 0.
- `hour`, in, 1: hour-step button, level, already debounced and synchronous.
- `minute`, in, 1: minute-step button, level.
- `down`, in, 1: 1 = decrement, 0 = increment; sampled on each step.
- `twenty_four_format`, in, 1: 1 = 24-hour display, 0 = 12-hour display.
- `hour_count`, out, 6: selected slot hour, 0–23.
- `min_count`, out, 6: selected slot minute, 0–59.
- `hour_bcd`, out, 8: display hour as two BCD digits, tens in [7:4].
- `min_bcd`, out, 8: minute as two BCD digits.
- `PM`, out, 1: 12-hour PM indicator.

## Operation
- Storage: NUM_SLOTS pairs of 6-bit hour/minute registers. Reset clears all of them to 00:00.
- Button FSM: states IDLE, HOLD_WAIT, REPEAT. `btn` = exactly one of `hour`/`minute` is high.
  - IDLE: when `btn` is high and `enable` is high, take one step and go to HOLD_WAIT with the repeat counter set to 0.
  - HOLD_WAIT: the counter increments each cycle. When it reaches REPEAT_DELAY-1, take one step, clear the counter, and go to REPEAT.
  - REPEAT: the counter increments each cycle. When it reaches REPEAT_PERIOD-1, take one step and clear the counter.
  - Any state returns to IDLE with no step when any of these occurs: `btn` drops; both buttons are high; `enable` is low; `sel_slot` changes.
- Both buttons high: treated as no press. If one button is released while the other stays held, that counts as a new press from IDLE.
- Step rules:
  - Minute up: 59→0. Minute down: 0→59.
  - Hour up: 23→0. Hour down: 0→23.
  - Only the selected slot changes.
- 12-hour decode (`twenty_four_format`=0):
  - hour 0 → 12, PM=0
  - 1–11 → same value, PM=0
  - 12 → 12, PM=1
  - 13–23 → hour−12, PM=1
- 24-hour decode (`twenty_four_format`=1): hour shown unchanged, PM=0.
- Binary-to-BCD conversion is combinational from the selected slot's registers.

## Timing
- Step latency: a step happens on the rising edge where the FSM condition is true. The new count is visible on all outputs immediately after that edge. Latency is 0 cycles beyond the edge.
- `sel_slot` and `twenty_four_format` act combinationally on the outputs, with no register stage.
- Held button, first step at edge E: second step at E+REPEAT_DELAY, then every REPEAT_PERIOD edges after that.
- Reset values: `hour_count`=0, `min_count`=0, `min_bcd`=8'h00, `PM`=0, FSM=IDLE, counter=0. `hour_bcd` is 8'h12 in 12-hour mode and 8'h00 in 24-hour mode.
- Reset asserted mid-hold: state clears immediately. After release, a button still held does not step until it is released and pressed again, because the FSM stays in HOLD_WAIT-equivalent lockout.

## Configuration
- Macro: `ALARM_SLOT_CARRY_EN`.
- Defined: a minute wrap carries into the hour in the same cycle.
  - Up 59→0 increments the hour, including 23:59→00:00.
  - Down 0→59 decrements the hour, including 00:00→23:59.
- Not defined: minute and hour wrap independently. 10:59 + minute step → 10:00.

## Test plan
- Reset, 12-hour mode: `hour_bcd`=8'h12, `min_bcd`=8'h00, PM=0. Switch to 24-hour mode: `hour_bcd`=8'h00.
- REPEAT_DELAY=4, REPEAT_PERIOD=2, slot 1: hold `minute` for 10 cycles → steps at edges 0, 4, 6, 8, and `min_count`=4. Slot 0 is still 0.
- `down`=1, single `hour` press from 0 → `hour_count`=23. In 12-hour mode: `hour_bcd`=8'h11, PM=1. In 24-hour mode: `hour_bcd`=8'h23, PM=0.
- Both buttons high for 20 cycles → no change. Release `hour` while `minute` stays held → exactly one minute step on the next edge.
- Slot 2 at 23:59, one `minute` up press → 00:00 with `ALARM_SLOT_CARRY_EN` defined, 23:00 without it.
- Assert `reset` while holding `hour` in REPEAT, then release reset with the button still held → all slots 00:00, no further steps until the button is released and pressed again.

Source files
------------

// File: rtl/alarm_slot_loader.sv
// Multi-slot hour/minute loader with auto-repeat buttons and BCD/12-24h display decode.
// Optional ALARM_SLOT_CARRY_EN: minute wrap carries into the hour of the same slot.
module alarm_slot_loader #(
  parameter int NUM_SLOTS     = 4,
  parameter int SLOT_W        = 2,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [SLOT_W-1:0] sel_slot,
  input  logic              hour,
  input  logic              minute,
  input  logic              down,
  input  logic              twenty_four_format,
  output logic [5:0]        hour_count,
  output logic [5:0]        min_count,
  output logic [7:0]        hour_bcd,
  output logic [7:0]        min_bcd,
  output logic              PM
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lock;
  logic [SLOT_W-1:0]  sel_q;
  logic [5:0]         hour_r [NUM_SLOTS];
  logic [5:0]         min_r  [NUM_SLOTS];

  logic [SLOT_W-1:0]  slot;
  logic [5:0]         cur_h, cur_m, nxt_h, nxt_m, h_inc, h_dec, m_inc, m_dec, disp_h;
  logic               btn, abort, step;

  assign slot  = (32'(sel_slot) < NUM_SLOTS) ? sel_slot : '0;
  assign cur_h = hour_r[slot];
  assign cur_m = min_r[slot];

  assign btn   = hour ^ minute;
  assign abort = !btn || !enable || (sel_slot != sel_q);

  always_comb begin
    step = 1'b0;
    case (state)
      IDLE:      step = !abort && !lock;
      HOLD_WAIT: step = !abort && (cnt == DLY_LAST);
      REPEAT:    step = !abort && (cnt == PER_LAST);
      default:   step = 1'b0;
    endcase
  end

  assign h_inc = (cur_h == 6'd23) ? 6'd0  : cur_h + 6'd1;
  assign h_dec = (cur_h == 6'd0)  ? 6'd23 : cur_h - 6'd1;
  assign m_inc = (cur_m == 6'd59) ? 6'd0  : cur_m + 6'd1;
  assign m_dec = (cur_m == 6'd0)  ? 6'd59 : cur_m - 6'd1;

  always_comb begin
    nxt_h = cur_h;
    nxt_m = cur_m;
    if (hour) begin
      nxt_h = down ? h_dec : h_inc;
    end else begin
      nxt_m = down ? m_dec : m_inc;
`ifdef ALARM_SLOT_CARRY_EN
      if (down && cur_m == 6'd0)
        nxt_h = h_dec;
      else if (!down && cur_m == 6'd59)
        nxt_h = h_inc;
`endif
    end
  end

  // lock survives reset so a button held across reset must be released before it steps again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lock  <= 1'b1;
      sel_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        hour_r[i] <= '0;
        min_r[i]  <= '0;
      end
    end else begin
      sel_q <= sel_slot;
      if (!btn) lock <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!lock) begin
              state <= HOLD_WAIT;
              cnt   <= '0;
            end
          end
          HOLD_WAIT: begin
            if (cnt == DLY_LAST) begin
              state <= REPEAT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (cnt == PER_LAST) cnt <= '0;
            else                 cnt <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
      if (step) begin
        hour_r[slot] <= nxt_h;
        min_r[slot]  <= nxt_m;
      end
    end
  end

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] tens;
    logic [5:0] ones;
    tens = v / 6'd10;
    ones = v % 6'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  always_comb begin
    disp_h = cur_h;
    if (!twenty_four_format) begin
      if (cur_h == 6'd0)      disp_h = 6'd12;
      else if (cur_h > 6'd12) disp_h = cur_h - 6'd12;
    end
  end

  assign hour_count = cur_h;
  assign min_count  = cur_m;
  assign hour_bcd   = to_bcd(disp_h);
  assign min_bcd    = to_bcd(cur_m);
  assign PM         = !twenty_four_format && (cur_h >= 6'd12);

endmodule

// File: tb/tb_alarm_slot_loader.sv
// Directed bench for alarm_slot_loader: driver pushes expected output vectors, a negedge monitor compares.
module tb_alarm_slot_loader;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] sel_slot;
  logic       hour;
  logic       minute;
  logic       down;
  logic       twenty_four_format;
  logic [5:0] hour_count;
  logic [5:0] min_count;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic       PM;

  alarm_slot_loader #(
    .NUM_SLOTS(3), .SLOT_W(2), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sel_slot(sel_slot),
    .hour(hour), .minute(minute), .down(down),
    .twenty_four_format(twenty_four_format),
    .hour_count(hour_count), .min_count(min_count),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .PM(PM)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {hour_count, min_count, hour_bcd, min_bcd, PM}
  logic [28:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          pushed = 0;
  int          fails  = 0;
  logic [28:0] mon_exp, mon_act;
  string       mon_name;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {hour_count, min_count, hour_bcd, min_bcd, PM};
      checks++;
      if (mon_act !== mon_exp) begin
        fails++;
        $display("FAIL %s: got h=%0d m=%0d hb=%h mb=%h pm=%b, expected h=%0d m=%0d hb=%h mb=%h pm=%b",
                 mon_name, mon_act[28:23], mon_act[22:17], mon_act[16:9], mon_act[8:1], mon_act[0],
                 mon_exp[28:23], mon_exp[22:17], mon_exp[16:9], mon_exp[8:1], mon_exp[0]);
      end
    end
  end

  function automatic logic [28:0] mk(input int h, input int m, input logic [7:0] hb,
                                     input logic [7:0] mb, input logic pm);
    return {6'(h), 6'(m), hb, mb, pm};
  endfunction

  // driver tasks
  task automatic check(input string n, input logic [28:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    pushed++;
    @(negedge clk);
    #1;
  endtask

  task automatic press_min(input logic dn);
    down = dn;
    minute = 1'b1;
    @(posedge clk); #1;
    minute = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press_hour(input logic dn);
    down = dn;
    hour = 1'b1;
    @(posedge clk); #1;
    hour = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int rep_min[10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

  initial begin
    reset = 1'b1; enable = 1'b1; sel_slot = 2'd0;
    hour = 1'b0; minute = 1'b0; down = 1'b0; twenty_four_format = 1'b0;
    repeat (2) @(posedge clk);
    check("rst_12h", mk(0, 0, 8'h12, 8'h00, 1'b0));
    twenty_four_format = 1'b1;
    check("rst_24h", mk(0, 0, 8'h00, 8'h00, 1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    sel_slot = 2'd1;
    @(posedge clk); #1;

    // auto-repeat on slot 1: steps at held edges 0, 4, 6, 8
    minute = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("repeat_edge%0d", i), mk(0, rep_min[i], 8'h00, 8'(rep_min[i]), 1'b0));
    end
    minute = 1'b0;
    twenty_four_format = 1'b0;
    check("slot1_12h", mk(0, 4, 8'h12, 8'h04, 1'b0));
    sel_slot = 2'd0;
    check("slot0_untouched", mk(0, 0, 8'h12, 8'h00, 1'b0));
    @(posedge clk); #1;

    // single hour down from 0
    down = 1'b1;
    hour = 1'b1;
    @(posedge clk); #1;
    hour = 1'b0;
    check("hour_dn_12h", mk(23, 0, 8'h11, 8'h00, 1'b1));
    twenty_four_format = 1'b1;
    check("hour_dn_24h", mk(23, 0, 8'h23, 8'h00, 1'b0));
    @(posedge clk); #1;

    // both buttons held, then release hour
    down = 1'b0;
    hour = 1'b1;
    minute = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("both_held", mk(23, 0, 8'h23, 8'h00, 1'b0));
    hour = 1'b0;
    @(posedge clk); #1;
    minute = 1'b0;
    check("one_min_step", mk(23, 1, 8'h23, 8'h01, 1'b0));
    @(posedge clk); #1;
    check("no_extra_step", mk(23, 1, 8'h23, 8'h01, 1'b0));
    sel_slot = 2'd3;
    check("sel_out_of_range", mk(23, 1, 8'h23, 8'h01, 1'b0));

    // slot 2 to 23:59 then minute up
    sel_slot = 2'd2;
    @(posedge clk); #1;
    press_min(1'b1);
`ifndef ALARM_SLOT_CARRY_EN
    press_hour(1'b1);
`endif
    check("slot2_2359", mk(23, 59, 8'h23, 8'h59, 1'b0));
    press_min(1'b0);
`ifdef ALARM_SLOT_CARRY_EN
    check("minute_wrap", mk(0, 0, 8'h00, 8'h00, 1'b0));
`else
    check("minute_wrap", mk(23, 0, 8'h23, 8'h00, 1'b0));
`endif

    // reset during REPEAT with hour held
    sel_slot = 2'd1;
    @(posedge clk); #1;
    down = 1'b0;
    hour = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("repeat_hour", mk(3, 4, 8'h03, 8'h04, 1'b0));
    reset = 1'b1;
    check("rst_mid_hold", mk(0, 0, 8'h00, 8'h00, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("lockout", mk(0, 0, 8'h00, 8'h00, 1'b0));
    sel_slot = 2'd2;
    check("slot2_cleared", mk(0, 0, 8'h00, 8'h00, 1'b0));
    sel_slot = 2'd0;
    check("slot0_cleared", mk(0, 0, 8'h00, 8'h00, 1'b0));
    hour = 1'b0;
    @(posedge clk); #1;
    hour = 1'b1;
    @(posedge clk); #1;
    hour = 1'b0;
    check("repress_after_lock", mk(1, 0, 8'h01, 8'h00, 1'b0));
    @(posedge clk); #1;

    // final report
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d expected entries never compared", exp_q.size());
    end
    if (checks != pushed) begin
      fails++;
      $display("FAIL scoreboard: %0d checks scheduled, %0d evaluated", pushed, checks);
    end
    if (checks < 12) begin
      fails++;
      $display("FAIL scoreboard: only %0d checks evaluated", checks);
    end
    if (fails == 0) $display("PASS: all %0d checks matched", checks);
    else            $display("FAIL: %0d of %0d checks failed", fails, checks);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
